// File: rtl/riscv_core_pkg.sv
// riscv_core_pkg: shared constants and helpers for the integer register file
package riscv_core_pkg;
   localparam int ZERO_REG       = 0;
   localparam int SP_REG_DEFAULT = 2;
   localparam int XLEN_DEFAULT   = 32;
   function automatic logic [63:0] sp_reset_value(input int addr_width_dmem);
      return 64'(1) << addr_width_dmem;
   endfunction
endpackage

// File: rtl/regfile_read_port.sv
// regfile_read_port: one combinational read port with x0 mask, write bypass and busy lookup
module regfile_read_port
   import riscv_core_pkg::*;
#(
   parameter int XLEN     = XLEN_DEFAULT,
   parameter int NUM_REGS = 32,
   parameter int BYPASS   = 1,
   localparam int AW      = $clog2(NUM_REGS)
) (
   input  logic [AW-1:0]                    rs_addr,
   input  logic [NUM_REGS-1:0][XLEN-1:0]    regs,
   input  logic [NUM_REGS-1:0]              busy,
   input  logic                             wr_en,
   input  logic [AW-1:0]                    wr_addr,
   input  logic [XLEN-1:0]                  wr_data,
   output logic [XLEN-1:0]                  rs_data,
   output logic                             rs_busy
);
   logic zero, fwd;
   assign zero    = rs_addr == AW'(ZERO_REG);
   assign fwd     = (BYPASS != 0) && wr_en && (wr_addr == rs_addr);
   assign rs_data = zero ? '0 : fwd ? wr_data : regs[rs_addr];
   assign rs_busy = !zero && !fwd && busy[rs_addr];
endmodule

// File: rtl/regfile_scoreboard_nrd.sv
// regfile_scoreboard_nrd: N-read/1-write register file with per-register busy scoreboard
module regfile_scoreboard_nrd
   import riscv_core_pkg::*;
#(
   parameter int XLEN            = XLEN_DEFAULT,
   parameter int NUM_REGS        = 32,
   parameter int NUM_RD          = 2,
   parameter int SP_INDEX        = SP_REG_DEFAULT,
   parameter int ADDR_WIDTH_DMEM = 10,
   parameter int BYPASS          = 1,
   localparam int AW             = $clog2(NUM_REGS)
) (
   input  logic                     clk,
   input  logic                     async_reset,
   input  logic [NUM_RD*AW-1:0]     rs_addr,
   output logic [NUM_RD*XLEN-1:0]   rs_data,
   output logic [NUM_RD-1:0]        rs_busy,
   input  logic                     wr_en,
   input  logic [AW-1:0]            wr_addr,
   input  logic [XLEN-1:0]          wr_data,
   input  logic                     claim_en,
   input  logic [AW-1:0]            claim_addr,
   input  logic                     flush
);
   localparam logic [XLEN-1:0] SP_RESET = XLEN'(sp_reset_value(ADDR_WIDTH_DMEM));
   logic [NUM_REGS-1:0][XLEN-1:0] regs;
   logic [NUM_REGS-1:0]           busy, busy_nxt;
   logic                          wr_live, claim_live;
   assign wr_live    = wr_en && wr_addr != AW'(ZERO_REG);
   assign claim_live = claim_en && claim_addr != AW'(ZERO_REG);
   always_ff @(posedge clk or negedge async_reset) begin
      if (!async_reset) begin
         for (int i = 0; i < NUM_REGS; i++)
            regs[i] <= (i == SP_INDEX) ? SP_RESET : '0;
      end else if (wr_live) begin
         regs[wr_addr] <= wr_data;
      end
   end
   // Claim is applied last so a new producer supersedes a same-cycle retirement.
   always_comb begin
      busy_nxt = flush ? '0 : busy;
      if (wr_live) busy_nxt[wr_addr] = 1'b0;
      if (claim_live) busy_nxt[claim_addr] = 1'b1;
      busy_nxt[ZERO_REG] = 1'b0;
   end
   always_ff @(posedge clk or negedge async_reset) begin
      if (!async_reset) busy <= '0;
      else busy <= busy_nxt;
   end
   for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      regfile_read_port #(.XLEN(XLEN), .NUM_REGS(NUM_REGS), .BYPASS(BYPASS)) u_port (
         .rs_addr (rs_addr[k*AW +: AW]),
         .regs    (regs),
         .busy    (busy),
         .wr_en   (wr_en),
         .wr_addr (wr_addr),
         .wr_data (wr_data),
         .rs_data (rs_data[k*XLEN +: XLEN]),
         .rs_busy (rs_busy[k])
      );
   end
endmodule

// File: tb/tb_regfile_scoreboard_nrd.sv
// tb_regfile_scoreboard_nrd: table-driven scoreboard bench for the register file
module tb_regfile_scoreboard_nrd;
   logic        clk = 1'b0;
   logic        async_reset;
   logic [19:0] rs_addr;
   logic [127:0] rs_data;
   logic [3:0]  rs_busy;
   logic        wr_en, claim_en, flush;
   logic [4:0]  wr_addr, claim_addr;
   logic [31:0] wr_data;
   logic [31:0] nb_data;
   logic        nb_busy;
   int checks = 0;
   int errors = 0;
   typedef struct {
      logic we; logic [4:0] wa; logic [31:0] wd;
      logic ce; logic [4:0] ca; logic fl;
      logic [4:0] ra; logic [31:0] ed_a; logic eb_a;
      logic [4:0] rb; logic [31:0] ed_b; logic eb_b;
   } vec_t;
   typedef struct { string name; logic [31:0] d_a; logic b_a; logic [31:0] d_b; logic b_b; } exp_t;
   exp_t q[$];
   vec_t tbl[27];
   always #5 clk = ~clk;
   regfile_scoreboard_nrd #(.NUM_RD(4), .BYPASS(1)) dut (
      .clk(clk), .async_reset(async_reset), .rs_addr(rs_addr), .rs_data(rs_data),
      .rs_busy(rs_busy), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .claim_en(claim_en), .claim_addr(claim_addr), .flush(flush)
   );
   regfile_scoreboard_nrd #(.NUM_RD(1), .BYPASS(0)) dut_nb (
      .clk(clk), .async_reset(async_reset), .rs_addr(rs_addr[4:0]), .rs_data(nb_data),
      .rs_busy(nb_busy), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .claim_en(claim_en), .claim_addr(claim_addr), .flush(flush)
   );
   function automatic vec_t mk(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                               input logic ce, input logic [4:0] ca, input logic fl,
                               input logic [4:0] ra, input logic [31:0] ed_a, input logic eb_a,
                               input logic [4:0] rb, input logic [31:0] ed_b, input logic eb_b);
      return '{we, wa, wd, ce, ca, fl, ra, ed_a, eb_a, rb, ed_b, eb_b};
   endfunction
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", nm, act, exp);
      end
   endtask
   task automatic step(input int idx, input vec_t v);
      exp_t e;
      wr_en = v.we; wr_addr = v.wa; wr_data = v.wd;
      claim_en = v.ce; claim_addr = v.ca; flush = v.fl;
      rs_addr = {v.rb, v.ra, v.rb, v.ra};
      q.push_back('{$sformatf("vec%0d", idx), v.ed_a, v.eb_a, v.ed_b, v.eb_b});
      @(negedge clk);
      if (q.size() == 0) begin
         checks++; errors++;
         $display("FAIL %s scoreboard empty", $sformatf("vec%0d", idx));
      end else begin
         e = q.pop_front();
         for (int k = 0; k < 4; k++) begin
            chk($sformatf("%s_data%0d", e.name, k), rs_data[k*32 +: 32], (k % 2 == 0) ? e.d_a : e.d_b);
            chk($sformatf("%s_busy%0d", e.name, k), 32'(rs_busy[k]), 32'((k % 2 == 0) ? e.b_a : e.b_b));
         end
      end
      @(posedge clk);
      #1;
   endtask
   initial begin
      async_reset = 1'b0;
      wr_en = 0; wr_addr = 0; wr_data = 0; claim_en = 0; claim_addr = 0; flush = 0; rs_addr = '0;
      //          we wa  wd            ce ca fl  ra  ed_a          eb  rb  ed_b          eb
      tbl[0]  = mk(0, 0,  32'h0,        0, 0, 0,  0, 32'h0,        0,  2, 32'd1024,      0);
      tbl[1]  = mk(0, 0,  32'h0,        0, 0, 0,  2, 32'd1024,     0,  1, 32'h0,         0);
      tbl[2]  = mk(0, 0,  32'h0,        0, 0, 0,  5, 32'h0,        0,  2, 32'd1024,      0);
      tbl[3]  = mk(1, 5,  32'hDEADBEEF, 0, 0, 0,  5, 32'hDEADBEEF, 0,  5, 32'hDEADBEEF,  0);
      tbl[4]  = mk(0, 0,  32'h0,        0, 0, 0,  5, 32'hDEADBEEF, 0,  2, 32'd1024,      0);
      tbl[5]  = mk(1, 0,  32'hFFFFFFFF, 1, 0, 0,  0, 32'h0,        0,  0, 32'h0,         0);
      tbl[6]  = mk(0, 0,  32'h0,        0, 0, 0,  0, 32'h0,        0,  2, 32'd1024,      0);
      tbl[7]  = mk(0, 0,  32'h0,        1, 7, 0,  7, 32'h0,        0,  2, 32'd1024,      0);
      tbl[8]  = mk(0, 0,  32'h0,        0, 0, 0,  7, 32'h0,        1,  7, 32'h0,         1);
      tbl[9]  = mk(1, 7,  32'h77,       0, 0, 0,  7, 32'h77,       0,  2, 32'd1024,      0);
      tbl[10] = mk(0, 0,  32'h0,        0, 0, 0,  7, 32'h77,       0,  2, 32'd1024,      0);
      tbl[11] = mk(0, 0,  32'h0,        1, 7, 0,  7, 32'h77,       0,  2, 32'd1024,      0);
      tbl[12] = mk(1, 7,  32'h1234,     1, 7, 0,  7, 32'h1234,     0,  2, 32'd1024,      0);
      tbl[13] = mk(0, 0,  32'h0,        0, 0, 0,  7, 32'h1234,     1,  0, 32'h0,         0);
      tbl[14] = mk(0, 0,  32'h0,        1, 3, 0,  3, 32'h0,        0,  2, 32'd1024,      0);
      tbl[15] = mk(0, 0,  32'h0,        1, 4, 0,  3, 32'h0,        1,  2, 32'd1024,      0);
      tbl[16] = mk(0, 0,  32'h0,        1, 9, 0,  4, 32'h0,        1,  3, 32'h0,         1);
      tbl[17] = mk(0, 0,  32'h0,        1, 4, 1,  9, 32'h0,        1,  2, 32'd1024,      0);
      tbl[18] = mk(0, 0,  32'h0,        0, 0, 0,  9, 32'h0,        0,  4, 32'h0,         1);
      tbl[19] = mk(0, 0,  32'h0,        0, 0, 0,  4, 32'h0,        1,  3, 32'h0,         0);
      tbl[20] = mk(0, 0,  32'h0,        0, 0, 0,  3, 32'h0,        0,  7, 32'h1234,      0);
      tbl[21] = mk(0, 0,  32'h0,        0, 0, 0,  7, 32'h1234,     0,  2, 32'd1024,      0);
      tbl[22] = mk(1, 3,  32'hAA,       0, 0, 1,  3, 32'hAA,       0,  4, 32'h0,         1);
      tbl[23] = mk(0, 0,  32'h0,        0, 0, 0,  3, 32'hAA,       0,  4, 32'h0,         0);
      tbl[24] = mk(1, 9,  32'h99,       1, 3, 0,  9, 32'h99,       0,  2, 32'd1024,      0);
      tbl[25] = mk(0, 0,  32'h0,        0, 0, 0,  3, 32'hAA,       1,  9, 32'h99,        0);
      tbl[26] = mk(0, 0,  32'h0,        0, 0, 0,  4, 32'h0,        0,  7, 32'h1234,      0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      async_reset = 1'b1;
      @(posedge clk);
      #1;
      for (int a = 0; a < 32; a++) begin
         rs_addr = {4{5'(a)}};
         #1;
         chk($sformatf("rst_data_x%0d", a), rs_data[31:0], (a == 2) ? 32'd1024 : 32'h0);
         chk($sformatf("rst_busy_x%0d", a), 32'(rs_busy), 32'h0);
      end
      for (int i = 0; i < 27; i++) step(i, tbl[i]);
      wr_en = 1; wr_addr = 11; wr_data = 32'hCAFE; rs_addr = {4{5'd11}};
      @(negedge clk);
      chk("byp_on_pre", rs_data[31:0], 32'hCAFE);
      chk("byp_off_pre", nb_data, 32'h0);
      @(posedge clk);
      #1;
      wr_en = 0;
      #1;
      chk("byp_on_post", rs_data[31:0], 32'hCAFE);
      chk("byp_off_post", nb_data, 32'hCAFE);
      wr_en = 1; wr_addr = 5; wr_data = 32'h5555; claim_en = 1; claim_addr = 6;
      #2;
      async_reset = 1'b0;
      #1;
      rs_addr = {4{5'd2}};
      #1;
      for (int k = 0; k < 4; k++) chk($sformatf("mid_rst_sp%0d", k), rs_data[k*32 +: 32], 32'd1024);
      wr_en = 0; claim_en = 0;
      rs_addr = {5'd11, 5'd3, 5'd5, 5'd7};
      #1;
      chk("mid_rst_x7", rs_data[31:0], 32'h0);
      chk("mid_rst_x5", rs_data[63:32], 32'h0);
      chk("mid_rst_x3", rs_data[95:64], 32'h0);
      chk("mid_rst_x11", rs_data[127:96], 32'h0);
      chk("mid_rst_busy", 32'(rs_busy), 32'h0);
      @(negedge clk);
      async_reset = 1'b1;
      rs_addr = {5'd6, 5'd6, 5'd5, 5'd5};
      @(posedge clk);
      #1;
      chk("post_rst_x5", rs_data[31:0], 32'h0);
      chk("post_rst_busy6", 32'(rs_busy[3]), 32'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
